i2c_reg_controller: RTL

//   Sequences the byte stream from i2c_slave_serializer into a small bank of
//   8-bit registers. Decodes the address byte, loads a register pointer and

---
 rtl/i2c_reg_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/i2c_reg_controller.sv
// Register-bank sequencer behind the I2C slave serializer.
// Bytes land in shadow registers and are committed to regs_out together on STOP.
module i2c_reg_controller #(
  parameter logic [6:0]  I2C_ADDRESS = 7'h42,
  parameter int unsigned NUM_REGS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    wr,
  input  logic [7:0]              write_data,
  output logic                    selected,
  output logic [NUM_REGS*8-1:0]   regs_out,
  output logic                    update
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StPtr,
    StData,
    StIgnore
  } state_e;

  state_e state_q;

  logic [7:0]            ptr_q, ptr_d;
  logic [7:0]            shadow_q [NUM_REGS];
  logic [7:0]            shadow_d [NUM_REGS];
  logic                  dirty_q, dirty_d;
  logic [NUM_REGS*8-1:0] shadow_flat_d;
  logic                  byte_ok;
  logic                  addr_match;

  // A byte is consumed unless a START arrives with it; STOP (even with START) lets it through.
  assign byte_ok    = wr & (stop | ~start);
  assign addr_match = (write_data[7:1] == I2C_ADDRESS) & ~write_data[0];

  always_comb begin
    ptr_d    = ptr_q;
    dirty_d  = dirty_q;
    shadow_d = shadow_q;
    if (byte_ok && state_q == StPtr) begin
      ptr_d = write_data;
    end
    if (byte_ok && state_q == StData) begin
      ptr_d = ptr_q + 8'd1;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == 8'(i)) begin
          shadow_d[i] = write_data;
          dirty_d     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    shadow_flat_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_flat_d[8*i +: 8] = shadow_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      dirty_q  <= 1'b0;
      selected <= 1'b0;
      update   <= 1'b0;
      regs_out <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      update   <= 1'b0;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      if (stop) begin
        state_q  <= StIdle;
        selected <= 1'b0;
        // Commit uses next-state shadow so a byte arriving with STOP is included.
        if (dirty_d) begin
          regs_out <= shadow_flat_d;
          update   <= 1'b1;
          dirty_q  <= 1'b0;
        end
      end else if (start) begin
        state_q  <= StAddr;
        selected <= 1'b0;
      end else if (wr) begin
        unique case (state_q)
          StAddr: begin
            if (addr_match) begin
              state_q  <= StPtr;
              selected <= 1'b1;
            end else begin
              state_q <= StIgnore;
            end
          end
          StPtr:   state_q <= StData;
          default: state_q <= state_q;
        endcase
      end
    end
  end

endmodule
